// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3/memory encodings, FSM state type and request legality check
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] MEM_WORD = 3'b010;
    localparam logic [2:0] MEM_BYTE = 3'b000;
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} lsu_state_t;
    // Stores have no unsigned variants, so BU/HU are legal only for loads
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (!we && ((f3 == F3_BU) || (f3 == F3_HU)));
    endfunction
endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: sign/zero-extends an assembled byte or halfword load result
//   funct3 : RV32I load width (B, H, BU, HU)
//   raw    : assembled low halfword, byte loads use only the low byte
//   rdata  : DATA_WIDTH extended result
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic [2:0]              funct3,
    input  logic [2*BYTE_WIDTH-1:0] raw,
    output logic [DATA_WIDTH-1:0]   rdata
);
    logic sign;
    logic half;
    assign half  = (funct3 == F3_H) || (funct3 == F3_HU);
    assign sign  = ((funct3 == F3_B) && raw[BYTE_WIDTH-1]) || ((funct3 == F3_H) && raw[2*BYTE_WIDTH-1]);
    assign rdata = half ? {{(DATA_WIDTH-2*BYTE_WIDTH){sign}}, raw}
                        : {{(DATA_WIDTH-BYTE_WIDTH){sign}}, raw[BYTE_WIDTH-1:0]};
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit initiator side of the data-memory port
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   req_*                          : one load/store request per valid/ready handshake
//   resp_*                         : extended load data or store ack, error flag
//   mem_*                          : word / zero-extended byte memory port, combinational read data
//   Halfwords are split into two byte accesses (addr, addr+1).
//   Build option LSU_MISALIGN_TRAP_EN: misaligned W/H/HU return an error without accessing memory.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [2:0]               req_funct3_i,
    input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0]    req_wdata_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [DATA_WIDTH-1:0]    resp_rdata_o,
    output logic                     resp_err_o,
    output logic                     mem_wr_en_o,
    output logic [2:0]               mem_funct3_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);
    lsu_state_t               state;
    logic                     we_q;
    logic                     err_q;
    logic [2:0]               f3_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [DATA_WIDTH-1:0]    ext_rdata;
    logic                     misalign;
    logic                     req_err;
    logic                     is_word;
    logic                     in_acc;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_funct3_i == F3_W) && (req_addr_i[1:0] != 2'b00)) ||
                      (((req_funct3_i == F3_H) || (req_funct3_i == F3_HU)) && req_addr_i[0]);
`else
    assign misalign = 1'b0;
`endif

    assign req_err = !f3_legal(req_we_i, req_funct3_i) || misalign;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    we_q    <= req_we_i;
                    f3_q    <= req_funct3_i;
                    addr_q  <= req_addr_i;
                    wdata_q <= req_wdata_i;
                    err_q   <= req_err;
                    state   <= req_err ? RESP : ACC0;
                end
                ACC0: begin
                    if (!we_q) data_q <= is_word ? mem_rdata_i : DATA_WIDTH'(mem_rdata_i[BYTE_WIDTH-1:0]);
                    state <= ((f3_q == F3_H) || (f3_q == F3_HU)) ? ACC1 : RESP;
                end
                ACC1: begin
                    if (!we_q) data_q[2*BYTE_WIDTH-1:BYTE_WIDTH] <= mem_rdata_i[BYTE_WIDTH-1:0];
                    state <= RESP;
                end
                RESP: if (resp_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    lsu_load_extend #(
        .DATA_WIDTH(DATA_WIDTH),
        .BYTE_WIDTH(BYTE_WIDTH)
    ) u_extend (
        .funct3(f3_q),
        .raw   (data_q[2*BYTE_WIDTH-1:0]),
        .rdata (ext_rdata)
    );

    // Memory side is decoded from state so an async reset drops it immediately
    assign is_word      = f3_q == F3_W;
    assign in_acc       = (state == ACC0) || (state == ACC1);
    assign req_ready_o  = state == IDLE;
    assign resp_valid_o = state == RESP;
    assign resp_err_o   = resp_valid_o && err_q;
    assign resp_rdata_o = (resp_valid_o && !we_q && !err_q) ? (is_word ? data_q : ext_rdata) : '0;
    assign mem_wr_en_o  = in_acc && we_q;
    assign mem_funct3_o = (state == ACC0 && is_word) ? MEM_WORD : MEM_BYTE;
    assign mem_addr_o   = (state == ACC0) ? addr_q :
                          (state == ACC1) ? addr_q + ADDRESS_WIDTH'(1) : '0;
    assign mem_wdata_o  = (state == ACC0) ? (is_word ? wdata_q : DATA_WIDTH'(wdata_q[BYTE_WIDTH-1:0])) :
                          (state == ACC1) ? DATA_WIDTH'(wdata_q[2*BYTE_WIDTH-1:BYTE_WIDTH]) : '0;
endmodule
